bcd_serial_add_ctrl: RTL and testbench
======================================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter: DIGITS, default 4, number of packed BCD digits per operand (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operands presented on op_a/op_b.
REQ-005 Port: in_ready  output  1  block can accept a new operand pair.
REQ-006 Port: op_a  input  4*DIGITS  augend, packed BCD, digit 0 in bits [3:0].
REQ-007 Port: op_b  input  4*DIGITS  addend, packed BCD, same packing as op_a.
REQ-008 Port: out_valid  output  1  sum, carry_out and err are valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: sum  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0].
REQ-011 Port: carry_out  output  1  decimal carry out of the most significant digit.
REQ-012 Port: err  output  1  at least one operand digit was greater than 9.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-016 On a transfer, the block SHALL latch op_a/op_b, clear the digit index and internal carry, and clear sum, carry_out and err.
REQ-017 On a transfer with all 2*DIGITS operand digits at most 9, the next state SHALL be ADD.
REQ-018 On a transfer with any operand digit greater than 9, the next state SHALL be DONE with err=1, sum=0 and carry_out=0, and no ADD cycles SHALL occur.
REQ-019 Each ADD cycle SHALL process exactly one digit i, lowest index first, using one shared digit adder.
REQ-020 Digit arithmetic: t = a_i + b_i + c with 5-bit width (range 0..19).
REQ-021 If t > 9, then sum digit i = t - 10 (equivalently (t+6) mod 16) and c = 1.
REQ-022 If t <= 9, then sum digit i = t and c = 0.
REQ-023 After digit DIGITS-1 the FSM SHALL enter DONE with carry_out equal to the final c.
REQ-024 Latency: out_valid SHALL rise exactly DIGITS+1 clock edges after the accepting edge.
REQ-025 Latency for an err transfer: out_valid SHALL rise 1 edge after the accepting edge.
REQ-026 In DONE, out_valid SHALL be 1, and sum, carry_out and err SHALL hold stable until out_ready=1.
REQ-027 DONE with out_ready=1 SHALL transition to IDLE on that edge.
REQ-028 in_ready SHALL stay 0 during the DONE-to-IDLE cycle, so a new transfer cannot complete before the following edge.
REQ-029 sum, carry_out and err SHALL retain their last values in IDLE until the next transfer.
REQ-030 in_valid SHALL be ignored in ADD and DONE.
REQ-031 Operand inputs SHALL NOT affect an in-flight operation.
REQ-032 Partial sum digits SHALL be visible on sum during ADD, but are not valid until out_valid=1.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, the digit index to 0, the internal carry to 0, sum to 0, carry_out to 0, err to 0, out_valid to 0 and busy to 0.
REQ-034 While rst_n=0, in_ready SHALL be 0, and in_ready SHALL become 1 on the first clock edge after rst_n deasserts.
REQ-035 Reset asserted in ADD or DONE SHALL abort the operation, and no out_valid pulse SHALL appear for it.

Verification
REQ-036 DIGITS=4, op_a=0x0999, op_b=0x0001 -> sum=0x1000, carry_out=0, err=0, out_valid 5 edges after accept.
REQ-037 op_a=0x9999, op_b=0x0001 -> sum=0x0000, carry_out=1; op_a=0x1234, op_b=0x5678 -> sum=0x6912, carry_out=0.
REQ-038 op_a=0x00A5, op_b=0x0001 -> err=1, sum=0, carry_out=0, out_valid 1 edge after accept.
REQ-039 Back-pressure: out_ready=0 for 3 cycles in DONE -> outputs stable; in_valid=1 held throughout is not accepted until IDLE.
REQ-040 rst_n pulsed low in the 2nd ADD cycle -> all outputs 0 immediately, no out_valid, and the next transfer after reset completes correctly.
REQ-041 Back-to-back: two transfers with out_ready tied 1 -> the second accept occurs exactly 2 edges after the first result's out_valid rises.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: accepts an operand pair, adds one digit per cycle
// through a single decimal digit adder, and holds the result until it is consumed.
//
// state | meaning
// IDLE  | waiting for operands; also hosts the one-cycle digit-validity check after a transfer
// ADD   | one digit per cycle, lowest index first
// DONE  | result valid, held until out_ready
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] op_a,
   input  logic [4*DIGITS-1:0] op_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] sum,
   output logic                carry_out,
   output logic                err,
   output logic                busy
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            c_q, c_d;
   logic            cout_q, cout_d;
   logic            err_q, err_d;
   logic            pend_q, pend_d;
   logic            boot_q, boot_d;

   logic [3:0]      dig_a, dig_b, dig_s;
   logic [4:0]      dig_t;
   logic            dig_c;
   logic            bad_digit;
   logic            accept;

   assign in_ready  = boot_q && (state_q == IDLE) && !pend_q;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign carry_out = cout_q;
   assign err       = err_q;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((a_q[4*i +: 4] > 4'd9) || (b_q[4*i +: 4] > 4'd9)) begin
            bad_digit = 1'b1;
         end
      end
   end

   // The single shared digit adder; a sum above 9 wraps by adding 6 modulo 16.
   always_comb begin
      dig_a = a_q[4*idx_q +: 4];
      dig_b = b_q[4*idx_q +: 4];
      dig_t = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, c_q};
      dig_c = (dig_t > 5'd9);
      if (dig_c) begin
         dig_s = dig_t[3:0] + 4'd6;
      end else begin
         dig_s = dig_t[3:0];
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      c_d     = c_q;
      cout_d  = cout_q;
      err_d   = err_q;
      pend_d  = pend_q;
      boot_d  = 1'b1;

      case (state_q)
         IDLE: begin
            if (pend_q) begin
               pend_d = 1'b0;
               if (bad_digit) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = ADD;
               end
            end else if (accept) begin
               a_d    = op_a;
               b_d    = op_b;
               idx_d  = '0;
               c_d    = 1'b0;
               sum_d  = '0;
               cout_d = 1'b0;
               err_d  = 1'b0;
               pend_d = 1'b1;
            end
         end
         ADD: begin
            sum_d[4*idx_q +: 4] = dig_s;
            c_d                 = dig_c;
            if (idx_q == LAST_IDX) begin
               cout_d  = dig_c;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         boot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         boot_q  <= boot_d;
      end
   end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: directed cases, reset abort, back-to-back and
// random operand pairs against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          carry_out;
   logic          err;
   logic          busy;

   int checks = 0;
   int failures = 0;

   bcd_serial_add_ctrl #(.DIGITS(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: decode to integers, add in decimal, re-encode.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] s, output logic c, output logic e);
      int va, vb, tot, lim;
      va = 0; vb = 0; lim = 1; e = 1'b0; s = '0;
      for (int i = D - 1; i >= 0; i--) begin
         if (int'(a[4*i +: 4]) > 9 || int'(b[4*i +: 4]) > 9) e = 1'b1;
         va  = va * 10 + int'(a[4*i +: 4]);
         vb  = vb * 10 + int'(b[4*i +: 4]);
         lim = lim * 10;
      end
      tot = va + vb;
      c   = (tot >= lim);
      tot = tot % lim;
      for (int i = 0; i < D; i++) begin
         s[4*i +: 4] = 4'(tot % 10);
         tot = tot / 10;
      end
      if (e) begin
         s = '0;
         c = 1'b0;
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [W-1:0] es;
      logic         ec, ee;
      int           n, lat;
      model(a, b, es, ec, ee);
      in_valid = 1'b1; op_a = a; op_b = b; n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check_val("accept_wait", 32'(n < 100), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1)); op_a = W'($urandom); op_b = W'($urandom);
      check_val("ready_after_accept", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check_val("latency", 32'(lat), ee ? 32'd1 : 32'(D + 1));
      check_val("sum", 32'(sum), 32'(es));
      check_val("carry", 32'(carry_out), 32'(ec));
      check_val("err", 32'(err), 32'(ee));
      check_val("busy_done", 32'(busy), 32'd1);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
         check_val("hold_valid", 32'(out_valid), 32'd1);
         check_val("hold_sum", 32'(sum), 32'(es));
         check_val("hold_carry", 32'(carry_out), 32'(ec));
         check_val("hold_err", 32'(err), 32'(ee));
         check_val("hold_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check_val("idle_valid", 32'(out_valid), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_ready", 32'(in_ready), 32'd1);
      check_val("retain_sum", 32'(sum), 32'(es));
      check_val("retain_carry", 32'(carry_out), 32'(ec));
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_sum"}, 32'(sum), 32'd0);
      check_val({tag, "_carry"}, 32'(carry_out), 32'd0);
      check_val({tag, "_err"}, 32'(err), 32'd0);
      check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb, es1, es2;
      logic         ec1, ec2, ee1, ee2;
      int           n, k, rise, acc2, lat;
      logic         prev_rdy;

      #1;
      check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_ready_held", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check_val("ready_after_edge", 32'(in_ready), 32'd1);

      run_op(16'h0999, 16'h0001, 0);
      run_op(16'h9999, 16'h0001, 1);
      run_op(16'h1234, 16'h5678, 3);
      run_op(16'h00A5, 16'h0001, 2);

      // Reset during the second ADD cycle aborts the operation.
      in_valid = 1'b1; op_a = 16'h4321; op_b = 16'h1111;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      check_val("mid_add_busy", 32'(busy), 32'd1);
      check_val("mid_add_partial", 32'(sum), 32'h0002);
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check_val("abort_no_valid", 32'(out_valid), 32'd0);
      end
      run_op(16'h4321, 16'h1111, 0);

      // Back-to-back with out_ready tied high.
      model(16'h0456, 16'h0789, es1, ec1, ee1);
      model(16'h9000, 16'h1000, es2, ec2, ee2);
      out_ready = 1'b1; in_valid = 1'b1; op_a = 16'h0456; op_b = 16'h0789;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      op_a = 16'h9000; op_b = 16'h1000;
      prev_rdy = in_ready; k = 0; rise = -1; acc2 = -1;
      while (acc2 < 0 && k < 40) begin
         @(posedge clk); #1; k++;
         if (prev_rdy) acc2 = k;
         if (out_valid && rise < 0) begin
            rise = k;
            check_val("b2b_sum1", 32'(sum), 32'(es1));
            check_val("b2b_carry1", 32'(carry_out), 32'(ec1));
         end
         prev_rdy = in_ready;
      end
      in_valid = 1'b0;
      check_val("b2b_rise", 32'(rise), 32'(D + 1));
      check_val("b2b_gap", 32'(acc2 - rise), 32'd2);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check_val("b2b_latency2", 32'(lat), 32'(D + 1));
      check_val("b2b_sum2", 32'(sum), 32'(es2));
      check_val("b2b_carry2", 32'(carry_out), 32'(ec2));
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Random operand pairs, occasionally with an illegal digit.
      for (int t = 0; t < 40; t++) begin
         ra = '0; rb = '0;
         for (int i = 0; i < D; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(0, 9));
            rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            else                           rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         end
         run_op(ra, rb, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
